// File: rtl/rails_arbiter.sv
// Round-robin front end that time-shares one rails station checker between NREQ requesters.
// Optional WAITR watchdog is enabled by defining RAILS_ARB_TIMEOUT_EN.
module rails_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              res,
  output logic              err,
  output logic              busy,
  output logic [3:0]        rails_data,
  output logic              rails_rst,
  input  logic              rails_valid,
  input  logic              rails_result
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, HDR, LOAD, STREAM, WAITR, FIN} state_t;

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_win;
  logic [3:0]        r_cnt;
  logic [3:0]        r_idx;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic              r_res;
  logic              r_err;
  logic              r_railsRst;
  logic [3:0]        r_data;

`ifdef RAILS_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0]     r_tmo;
`endif

  logic              w_any;
  logic [PW-1:0]     w_next;
  logic [NREQ-1:0]   w_nextHot;
  logic [NREQ-1:0]   w_winHot;
  logic [3:0]        w_slice;
  logic              w_cntOk;

  // Search from r_ptr upward, wrapping, for the first pending request.
  always_comb begin
    int k;
    k      = 0;
    w_any  = 1'b0;
    w_next = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(r_ptr) + i) % NREQ;
      if (!w_any && req[k]) begin
        w_any  = 1'b1;
        w_next = PW'(k);
      end
    end
  end

  assign w_nextHot = NREQ'(1) << w_next;
  assign w_winHot  = NREQ'(1) << r_win;
  assign w_slice   = req_data[4*r_win +: 4];
  assign w_cntOk   = (w_slice != 4'd0) && (w_slice <= 4'd10);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_win      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_res      <= 1'b0;
      r_err      <= 1'b0;
      r_railsRst <= 1'b1;
      r_data     <= '0;
`ifdef RAILS_ARB_TIMEOUT_EN
      r_tmo      <= '0;
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          r_gnt      <= '0;
          r_data     <= '0;
          r_railsRst <= 1'b1;
          if (w_any) begin
            r_win   <= w_next;
            r_gnt   <= w_nextHot;
            r_state <= HDR;
          end
        end
        HDR: begin
          r_cnt <= w_slice;
          r_gnt <= '0;
          // An illegal count never releases the checker from reset.
          if (w_cntOk) begin
            r_railsRst <= 1'b0;
            r_data     <= w_slice;
            r_state    <= LOAD;
          end else begin
            r_err   <= 1'b1;
            r_res   <= 1'b0;
            r_done  <= w_winHot;
            r_state <= FIN;
          end
        end
        LOAD: begin
          r_gnt   <= w_winHot;
          r_idx   <= '0;
          r_state <= STREAM;
        end
        STREAM: begin
          if (r_idx == r_cnt - 4'd1) begin
            r_gnt   <= '0;
            r_data  <= '0;
            r_state <= WAITR;
`ifdef RAILS_ARB_TIMEOUT_EN
            r_tmo   <= '0;
`endif
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        WAITR: begin
          if (rails_valid) begin
            r_res      <= rails_result;
            r_err      <= 1'b0;
            r_done     <= w_winHot;
            r_railsRst <= 1'b1;
            r_state    <= FIN;
`ifdef RAILS_ARB_TIMEOUT_EN
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            r_res      <= 1'b0;
            r_err      <= 1'b1;
            r_done     <= w_winHot;
            r_railsRst <= 1'b1;
            r_state    <= FIN;
          end else begin
            r_tmo <= r_tmo + 1'b1;
`endif
          end
        end
        FIN: begin
          r_railsRst <= 1'b1;
          r_ptr      <= (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stream words bypass the register so the checker sees them in the granted cycle.
  assign rails_data = (r_state == STREAM) ? w_slice : r_data;
  assign gnt        = r_gnt;
  assign done       = r_done;
  assign res        = r_res;
  assign err        = r_err;
  assign rails_rst  = r_railsRst;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_rails_arbiter.sv
// Directed self-checking bench for rails_arbiter; the bench plays both the requesters and the checker.
// Define RAILS_ARB_TIMEOUT_EN to exercise the watchdog path instead of the indefinite wait.
module tb_rails_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [4*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              res;
  logic              err;
  logic              busy;
  logic [3:0]        rails_data;
  logic              rails_rst;
  logic              rails_valid = 1'b0;
  logic              rails_result = 1'b0;

  int passCount = 0;
  int checkCount = 0;

  logic [3:0] words [NREQ][16];
  int         idx [NREQ];

  int         rWinner, rGnt, rForeign, rBusy, rDone, rLogN, rRstLow, rWaitCyc, rTimedOut;
  logic       rRes, rErr;
  logic [3:0] rLog [16];

  rails_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .res(res), .err(err), .busy(busy),
    .rails_data(rails_data), .rails_rst(rails_rst),
    .rails_valid(rails_valid), .rails_result(rails_result)
  );

  always #5 clk = ~clk;

  // Each requester advances its word pointer on every granted edge.
  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!reset || done[i]) idx[i] <= 0;
      else if (gnt[i]) idx[i] <= idx[i] + 1;
    end
  end

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++)
      req_data[4*i +: 4] = (idx[i] < 16) ? words[i][idx[i]] : 4'h0;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] global watchdog expired");
  end

  task automatic setWords(input int r, input logic [63:0] p);
    for (int k = 0; k < 16; k++) words[r][k] = p[4*k +: 4];
  endtask

  task automatic doReset();
    reset = 1'b0;
    req = '0;
    rails_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs one transaction to completion, acting as the checker; records what it observed.
  task automatic runTxn(input logic result, input int delay, input bit respond);
    int  waitCnt;
    bit  seenLoad, seenStream, got;
    waitCnt = 0; seenLoad = 0; seenStream = 0; got = 0;
    rWinner = -1; rGnt = 0; rForeign = 0; rBusy = 0; rDone = 0; rLogN = 0;
    rRstLow = 0; rWaitCyc = 0; rTimedOut = 0; rRes = 1'bx; rErr = 1'bx;
    for (int cyc = 0; cyc < 300 && !got; cyc++) begin
      @(negedge clk);
      rails_valid = 1'b0;
      if (busy) rBusy++;
      if (gnt != '0) begin
        rGnt++;
        if (rWinner < 0)
          for (int i = NREQ - 1; i >= 0; i--) if (gnt[i]) rWinner = i;
        if (gnt != (NREQ'(1) << rWinner)) rForeign++;
      end
      if (!rails_rst) rRstLow++;
      if (!rails_rst && rWinner >= 0 && (gnt[rWinner] || !seenLoad)) begin
        if (rLogN < 16) rLog[rLogN] = rails_data;
        rLogN++;
        seenLoad = 1;
        if (gnt[rWinner]) seenStream = 1;
      end else if (!rails_rst && seenStream && gnt == '0) begin
        rWaitCyc++;
        waitCnt++;
        if (respond && waitCnt == delay) begin
          rails_valid  = 1'b1;
          rails_result = result;
        end
      end
      if (done != '0) begin
        rDone++;
        rRes = res;
        rErr = err;
        if (rWinner < 0 || done != (NREQ'(1) << rWinner)) rForeign++;
        if (rWinner >= 0) req[rWinner] = 1'b0;
        got = 1;
      end
    end
    if (!got) rTimedOut = 1;
    else begin
      @(negedge clk);
      if (done != '0) rDone++;
    end
  endtask

  task automatic test_reset();
    doReset();
    checkCount++; if (gnt !== 4'b0) $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); else passCount++;
    checkCount++; if (done !== 4'b0) $display("[TB] FAIL reset_done: got %b expected 0000", done); else passCount++;
    checkCount++; if (res !== 1'b0) $display("[TB] FAIL reset_res: got %b expected 0", res); else passCount++;
    checkCount++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
    checkCount++; if (rails_data !== 4'h0) $display("[TB] FAIL reset_data: got %h expected 0", rails_data); else passCount++;
    checkCount++; if (rails_rst !== 1'b1) $display("[TB] FAIL reset_rails_rst: got %b expected 1", rails_rst); else passCount++;
  endtask

  task automatic test_basic();
    logic [3:0] expLog [6];
    expLog = '{4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    setWords(0, 64'h543215);
    req[0] = 1'b1;
    runTxn(1'b1, 3, 1'b1);
    checkCount++; if (rTimedOut !== 0) $display("[TB] FAIL basic_timeout: got %0d expected 0", rTimedOut); else passCount++;
    checkCount++; if (rWinner !== 0) $display("[TB] FAIL basic_winner: got %0d expected 0", rWinner); else passCount++;
    checkCount++; if (rGnt !== 6) $display("[TB] FAIL basic_gnt_cycles: got %0d expected 6", rGnt); else passCount++;
    checkCount++; if (rForeign !== 0) $display("[TB] FAIL basic_onehot: got %0d expected 0", rForeign); else passCount++;
    checkCount++; if (rLogN !== 6) $display("[TB] FAIL basic_word_count: got %0d expected 6", rLogN); else passCount++;
    for (int k = 0; k < 6; k++) begin
      checkCount++;
      if (rLog[k] !== expLog[k]) $display("[TB] FAIL basic_data%0d: got %0d expected %0d", k, rLog[k], expLog[k]);
      else passCount++;
    end
    checkCount++; if (rDone !== 1) $display("[TB] FAIL basic_done_pulses: got %0d expected 1", rDone); else passCount++;
    checkCount++; if (rRes !== 1'b1) $display("[TB] FAIL basic_res: got %b expected 1", rRes); else passCount++;
    checkCount++; if (rErr !== 1'b0) $display("[TB] FAIL basic_err: got %b expected 0", rErr); else passCount++;
    checkCount++; if (rBusy !== 11) $display("[TB] FAIL basic_busy_cycles: got %0d expected 11", rBusy); else passCount++;
  endtask

  task automatic test_fairness();
    int expOrder [4];
    logic expRes [4];
    expOrder = '{0, 2, 0, 2};
    expRes   = '{1'b1, 1'b0, 1'b0, 1'b1};
    doReset();
    setWords(0, 64'h3213);
    setWords(2, 64'h1233);
    req[0] = 1'b1;
    req[2] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      if (t == 2) begin
        req[0] = 1'b1;
        req[2] = 1'b1;
      end
      runTxn(expRes[t], 2, 1'b1);
      checkCount++;
      if (rWinner !== expOrder[t]) $display("[TB] FAIL fair_winner%0d: got %0d expected %0d", t, rWinner, expOrder[t]);
      else passCount++;
      checkCount++;
      if (rGnt !== 4 || rForeign !== 0) $display("[TB] FAIL fair_gnt%0d: got %0d cycles/%0d foreign expected 4/0", t, rGnt, rForeign);
      else passCount++;
      checkCount++;
      if (rRes !== expRes[t] || rDone !== 1) $display("[TB] FAIL fair_res%0d: got res %b done %0d expected %b/1", t, rRes, rDone, expRes[t]);
      else passCount++;
    end
    checkCount++;
    if (rLog[1] !== 4'd3 || rLog[3] !== 4'd1) $display("[TB] FAIL fair_data2: got %0d,%0d expected 3,1", rLog[1], rLog[3]);
    else passCount++;
  endtask

  task automatic test_reject();
    logic [63:0] cnts [2];
    cnts = '{64'h0, 64'hB};
    for (int t = 0; t < 2; t++) begin
      setWords(1, cnts[t]);
      req[1] = 1'b1;
      runTxn(1'b1, 1, 1'b1);
      checkCount++;
      if (rWinner !== 1 || rDone !== 1) $display("[TB] FAIL reject%0d_done: got winner %0d done %0d expected 1/1", t, rWinner, rDone);
      else passCount++;
      checkCount++;
      if (rErr !== 1'b1 || rRes !== 1'b0) $display("[TB] FAIL reject%0d_flags: got err %b res %b expected 1/0", t, rErr, rRes);
      else passCount++;
      checkCount++;
      if (rGnt !== 1) $display("[TB] FAIL reject%0d_gnt: got %0d expected 1", t, rGnt); else passCount++;
      checkCount++;
      if (rRstLow !== 0) $display("[TB] FAIL reject%0d_rails_rst: got %0d low cycles expected 0", t, rRstLow); else passCount++;
      checkCount++;
      if (rBusy !== 2) $display("[TB] FAIL reject%0d_busy: got %0d expected 2", t, rBusy); else passCount++;
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 0;
    setWords(3, 64'h543215);
    setWords(1, 64'h772);
    req[3] = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (gnt[3] && !rails_rst) found = 1;
    end
    checkCount++;
    if (!found) $display("[TB] FAIL midreset_stream: got no STREAM expected STREAM within 20 cycles"); else passCount++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkCount++; if (gnt !== 4'b0) $display("[TB] FAIL midreset_gnt: got %b expected 0000", gnt); else passCount++;
    checkCount++; if (rails_rst !== 1'b1) $display("[TB] FAIL midreset_rails_rst: got %b expected 1", rails_rst); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", busy); else passCount++;
    checkCount++; if (done !== 4'b0) $display("[TB] FAIL midreset_done: got %b expected 0000", done); else passCount++;
    reset = 1'b1;
    req[1] = 1'b1;
    runTxn(1'b0, 1, 1'b1);
    checkCount++; if (rWinner !== 1) $display("[TB] FAIL midreset_first: got %0d expected 1", rWinner); else passCount++;
    runTxn(1'b1, 1, 1'b1);
    checkCount++;
    if (rWinner !== 3 || rRes !== 1'b1) $display("[TB] FAIL midreset_second: got %0d res %b expected 3/1", rWinner, rRes);
    else passCount++;
  endtask

  task automatic test_timeout();
    setWords(0, 64'h442);
    req[0] = 1'b1;
    runTxn(1'b0, 0, 1'b0);
`ifdef RAILS_ARB_TIMEOUT_EN
    checkCount++; if (rTimedOut !== 0 || rDone !== 1) $display("[TB] FAIL tmo_done: got %0d done expected 1", rDone); else passCount++;
    checkCount++; if (rWaitCyc !== 16) $display("[TB] FAIL tmo_wait_cycles: got %0d expected 16", rWaitCyc); else passCount++;
    checkCount++; if (rErr !== 1'b1 || rRes !== 1'b0) $display("[TB] FAIL tmo_flags: got err %b res %b expected 1/0", rErr, rRes); else passCount++;
`else
    checkCount++; if (rDone !== 0) $display("[TB] FAIL nowait_done: got %0d expected 0", rDone); else passCount++;
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL nowait_busy: got %b expected 1", busy); else passCount++;
    checkCount++; if (rails_rst !== 1'b0) $display("[TB] FAIL nowait_rails_rst: got %b expected 0", rails_rst); else passCount++;
    doReset();
`endif
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) setWords(i, 64'h0);
    test_reset();
    test_basic();
    test_fairness();
    test_reject();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rails_arbiter.md
# rails_arbiter

Round-robin scheduler that shares one `rails` station checker between up to `NREQ` requesters. It accepts a train sequence from the winning requester, replays the count word and then the data words onto the checker's serial `data` bus. It waits for the checker's `valid`, then returns the result to that requester. The checker is held in reset whenever no transaction is active, so every sequence starts from a clean station.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 255: watchdog limit in cycles, used only with `RAILS_ARB_TIMEOUT_EN`.

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  NREQ  request level per requester; held until `done`.
- `req_data`  in  4*NREQ  requester i drives `req_data[4i+3:4i]`; advances one word per cycle its `gnt` bit is high.
- `gnt`  out  NREQ  one-hot word strobe to the winner.
- `done`  out  NREQ  one-cycle completion pulse to the winner.
- `res`  out  1  result, valid with `done`.
- `err`  out  1  error flag, valid with `done`.
- `busy`  out  1  high in every state except IDLE.
- `rails_data`  out  4  to checker `data`.
- `rails_rst`  out  1  to checker `reset` (active-high).
- `rails_valid`  in  1  from checker `valid`.
- `rails_result`  in  1  from checker `result`.

## Operation
- States: IDLE, HDR, LOAD, STREAM, WAITR, FIN.
- **IDLE**
  - `rails_rst`=1, `rails_data`=0, `gnt`=0.
  - If any `req` bit is set, choose winner `w`: the first set bit searching from `ptr`, wrapping modulo NREQ.
  - Register `w`, go to HDR.
- **HDR**
  - `gnt[w]`=1; sample `cnt` = word 0. `rails_rst` stays 1.
  - If `cnt` is 1..10, go to LOAD. Otherwise set `err`=1 and `res`=0, go to FIN; the checker is never released.
- **LOAD**
  - `gnt`=0, `rails_rst`=0, `rails_data`=`cnt`. The checker is in NUMBER_IN and latches the count.
- **STREAM**
  - `gnt[w]`=1 for exactly `cnt` cycles.
  - `rails_data` = `req_data` slice `w`, passed through combinationally.
  - A 4-bit word counter advances each cycle and exits at `cnt`.
- **WAITR**
  - `gnt`=0, `rails_data`=0; wait for `rails_valid`=1.
  - On `rails_valid`, capture `rails_result` into `res`, clear `err`, go to FIN.
- **FIN**
  - `done[w]`=1 for one cycle; `res` and `err` are stable in this cycle.
  - `rails_rst`=1; `ptr` ← (`w`+1) mod NREQ; go to IDLE.
- Requests are not re-checked after grant. Dropping `req[w]` mid-transaction is ignored and the transaction completes.

## Timing
- Reset values: `gnt`=0, `done`=0, `res`=0, `err`=0, `busy`=0, `rails_data`=0, `rails_rst`=1, `ptr`=0, state IDLE.
- Reset low in any state takes effect at the next edge and abandons the current transaction without a `done`. The checker is re-held in reset.
- `req` sampled in IDLE at edge t:
  - HDR at t+1, LOAD at t+2, STREAM at t+3 .. t+2+cnt.
  - `rails_valid` is seen no earlier than WAITR; FIN is the cycle after `rails_valid` is sampled; IDLE follows.
- Minimum request-to-request spacing is one IDLE cycle after FIN.
- `gnt` total high cycles per accepted transaction = 1+`cnt`; per rejected transaction = 1.
- Simultaneous requests: only the winner sees `gnt`; the others wait in IDLE ordering.
- After a grant to requester N-1, `ptr` wraps to 0.

## Configuration
- `RAILS_ARB_TIMEOUT_EN` defined:
  - An 8-bit-or-wider cycle counter runs in WAITR.
  - When it reaches `TIMEOUT` without `rails_valid`, go to FIN with `res`=0 and `err`=1.
  - This is required for non-realizable sequences, on which the checker never asserts `valid`.
- `RAILS_ARB_TIMEOUT_EN` undefined:
  - No counter; WAITR waits indefinitely.
  - `err` only reports an illegal count.

## Test plan
- req[0] with words 5,1,2,3,4,5; checker model returns result 1 → `gnt[0]` high 1 cycle (HDR) then 5 cycles (STREAM); `rails_data` sequence 5,1,2,3,4,5; `done[0]` pulse with `res`=1, `err`=0.
- req[0] and req[2] both set after reset, each with count 3 → served in order 0 then 2. Re-raise both → served 2 then 0 is not allowed; `ptr` after 2 is 3, so 0 is served next, then 2.
- req[1] with count 0, then count 11 → each gives `done[1]` with `err`=1, `res`=0, `rails_rst` stays 1 throughout, and `gnt` is high for only the HDR cycle.
- With `RAILS_ARB_TIMEOUT_EN` and `TIMEOUT`=16, `rails_valid` tied 0 → `done` occurs exactly 16 WAITR cycles after STREAM ends, with `err`=1. Without the macro, `busy` stays high indefinitely.
- Reset low during STREAM of requester 3 → next cycle `gnt`=0, `rails_rst`=1, `busy`=0, no `done`. A subsequent req[1] and req[3] together → requester 1 is granted first (`ptr`=0).
